std_rr_onehot_arbiter: RTL and testbench
========================================

# std_rr_onehot_arbiter

Round-robin arbiter that produces the one-hot grant vectors consumed and checked by the `std_onehot` population checker. It sits in front of shared resources such as bus ports and FIFO write slots. It takes W request lines and presents at most one grant per cycle on a valid/ready handshake. A grant is held stable under backpressure, and priority rotates past each accepted winner.

## Interface
- `W`, default 4: number of requesters; legal range 1..64.
- `IW`, derived, not overridable: `max(1, $clog2(W))`.
- `i_clk`, input, 1: clock; all state updates on the rising edge.
- `i_rst`, input, 1: reset; asynchronous, active-low.
- `i_req`, input, W: request vector; bit k set means requester k wants a grant.
- `i_ready`, input, 1: downstream accepts the current grant this cycle.
- `o_valid`, output, 1: a grant is presented.
- `o_grant`, output, W: one-hot grant; all-zero when `o_valid` = 0.
- `o_index`, output, IW: binary index of the granted bit; 0 when `o_valid` = 0.

## Operation
- State:
  - `prio`, W-bit one-hot, marks the highest-priority position. Reset value is `1` (bit 0).
  - `locked`, 1 bit. Reset value is 0.
  - `lgrant`, W bits. Reset value is 0.
- Unlocked (`locked` = 0):
  - `o_valid = |i_req`.
  - `o_grant` is the first set bit of `i_req`, scanning upward from the `prio` position and wrapping from bit W-1 to bit 0.
  - Implement with a double-width masked priority scan or an equivalent; no loops that depend on data.
- Locked (`locked` = 1): `o_valid` = 1 and `o_grant` = `lgrant`, regardless of `i_req`.
- Accept event, `o_valid & i_ready`:
  - `prio` <= `o_grant` rotated left by 1 (bit W-1 wraps to bit 0).
  - `locked` <= 0.
- Stall event, `o_valid & ~i_ready`: `locked` <= 1 and `lgrant` <= `o_grant`. `prio` is unchanged.
- No request (`o_valid` = 0): all state holds.
- Requester protocol: a requester keeps its request asserted until granted. If a request is dropped while locked, the grant is still held until accepted; this is defined behaviour, not an error.
- `o_index` is the one-hot-to-binary encoding (OR-reduction per bit) of `o_grant`.
- W = 1: `o_grant = i_req`, `o_index` = 0, and `prio` is the constant 1.
- Invariants:
  - `o_grant` has exactly one bit set when `o_valid` = 1 and is zero otherwise.
  - A continuously requesting line is granted within W accepts.

## Timing
- `i_req` to `o_grant`/`o_valid`/`o_index` is combinational (zero latency) when unlocked. Once locked, these outputs come from registers.
- `i_ready` affects only the next-state logic. There is no combinational path from `i_ready` to any output.
- During and immediately after reset (`prio` = 1, `locked` = 0), outputs follow fixed priority from bit 0. With `i_req` = 0, the outputs are `o_valid` = 0, `o_grant` = 0 and `o_index` = 0.
- If reset is asserted mid-lock, `locked`, `lgrant` and `prio` clear asynchronously, and the held grant is dropped in the same cycle.
- Throughput is one accepted grant per cycle with `i_ready` held high.
- The rotation after an accepted grant takes effect in the following cycle.

## Test plan
- Reset, `i_req` = 0000: `o_valid` = 0, `o_grant` = 0000, `o_index` = 0.
- W = 4, `i_req` = 1111 and `i_ready` = 1 for 5 cycles:
  - Grants are 0001, 0010, 0100, 1000, 0001.
  - `o_index` is 0, 1, 2, 3, 0.
- Backpressure:
  - `i_req` = 1010, `i_ready` = 0 for 3 cycles: `o_grant` = 0010 held in all 3 cycles.
  - Then `i_req` = 1000: `o_grant` is still 0010.
  - Then `i_ready` = 1: accepted, and the next cycle shows `o_grant` = 1000.
- Wrap-around:
  - After an accepted grant on bit 3, `prio` = 0001.
  - Then `i_req` = 0110: `o_grant` = 0010, `o_index` = 1.
- Reset mid-lock:
  - Lock on 0100 with `i_ready` = 0, then pulse `i_rst` low between clock edges: `o_grant` immediately follows unlocked arbitration.
  - After release, with `i_req` = 1001: `o_grant` = 0001.
- Random `i_req`/`i_ready` for 10k cycles with W in {1, 3, 4, 7}:
  - Feed `o_grant` into `std_onehot`: require `o_onehot == o_valid` and `o_zero == ~o_valid` every cycle.
  - A scoreboard checks hold-under-stall and that every persistent requester is served within W accepts.

Source files
------------

// File: rtl/std_rr_onehot_arbiter_if.sv
// Request/grant bundle between W requesters and the round-robin arbiter.
// master = arbiter side (drives the grant), slave = requester/consumer side.
interface std_rr_onehot_arbiter_if #(
  parameter int W = 4
);
  localparam int IW = (W > 1) ? $clog2(W) : 1;

  logic [W-1:0]  req;
  logic          ready;
  logic          valid;
  logic [W-1:0]  grant;
  logic [IW-1:0] index;

  modport master (
    input  req,
    input  ready,
    output valid,
    output grant,
    output index
  );

  modport slave (
    output req,
    output ready,
    input  valid,
    input  grant,
    input  index
  );
endinterface

// File: rtl/std_rr_onehot_arbiter.sv
// Round-robin one-hot arbiter; unlocked grant is combinational from req, locked grant comes from registers.
// A stalled grant (valid & ~ready) is latched and held until accepted; priority rotates past each accepted winner.
module std_rr_onehot_arbiter #(
  parameter int W = 4
) (
  input logic                          i_clk,
  input logic                          i_rst,
  std_rr_onehot_arbiter_if.master      io_bus
);
  localparam int IW = (W > 1) ? $clog2(W) : 1;

  logic [W-1:0]  w_req;
  logic [W-1:0]  w_scan;
  logic [W-1:0]  w_grant;
  logic          w_valid;
  logic [IW-1:0] w_index;

  logic          r_locked;
  logic [W-1:0]  r_lgrant;

  assign w_req = io_bus.req;

  generate
    if (W == 1) begin : g_single
      assign w_scan = w_req;
    end else begin : g_multi
      logic [W-1:0]   r_prio;
      logic [2*W-1:0] w_dreq;
      logic [2*W-1:0] w_dscan;

      // Subtracting prio clears the first set request at/above prio in the doubled vector;
      // the AND-NOT isolates that bit, and folding both halves handles the wrap.
      assign w_dreq  = {w_req, w_req};
      assign w_dscan = w_dreq & ~(w_dreq - {{W{1'b0}}, r_prio});
      assign w_scan  = w_dscan[W-1:0] | w_dscan[2*W-1:W];

      always_ff @(posedge i_clk or negedge i_rst) begin
        if (!i_rst) begin
          r_prio <= W'(1);
        end else if (w_valid && io_bus.ready) begin
          r_prio <= {w_grant[W-2:0], w_grant[W-1]};
        end
      end
    end
  endgenerate

  assign w_valid = r_locked | (|w_req);
  assign w_grant = r_locked ? r_lgrant : w_scan;

  always_comb begin
    w_index = '0;
    for (int k = 0; k < W; k++) begin
      if (w_grant[k]) begin
        w_index = w_index | IW'(k);
      end
    end
  end

  always_ff @(posedge i_clk or negedge i_rst) begin
    if (!i_rst) begin
      r_locked <= 1'b0;
      r_lgrant <= '0;
    end else if (w_valid) begin
      if (io_bus.ready) begin
        r_locked <= 1'b0;
      end else begin
        r_locked <= 1'b1;
        r_lgrant <= w_grant;
      end
    end
  end

  assign io_bus.valid = w_valid;
  assign io_bus.grant = w_grant;
  assign io_bus.index = w_index;
endmodule

// File: tb/tb_std_rr_onehot_arbiter.sv
// Directed W=4 vectors plus randomised runs at W = 1, 3, 4, 7 against a loop-scan reference model.
module tb_std_rr_onehot_arbiter;
  logic clk;
  logic rst_n;
  bit   rnd_go;
  int   n_cmp;
  int   n_err;

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_cmp++;
    if (obs !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  std_rr_onehot_arbiter_if #(.W(4)) u_if4 ();
  std_rr_onehot_arbiter #(.W(4)) u_dut (
    .i_clk  (clk),
    .i_rst  (rst_n),
    .io_bus (u_if4.master)
  );

  task automatic drive(input logic [3:0] r, input logic rd);
    @(posedge clk);
    #1;
    u_if4.req   = r;
    u_if4.ready = rd;
    @(negedge clk);
  endtask

  task automatic expect4(input string tag, input logic v, input logic [3:0] g, input logic [1:0] ix);
    chk({tag, "_valid"}, 64'(u_if4.valid), 64'(v));
    chk({tag, "_grant"}, 64'(u_if4.grant), 64'(g));
    chk({tag, "_index"}, 64'(u_if4.index), 64'(ix));
  endtask

  for (genvar g = 0; g < 4; g++) begin : g_rnd
    localparam int WG = (g == 0) ? 1 : (g == 1) ? 3 : (g == 2) ? 4 : 7;
    bit done;

    std_rr_onehot_arbiter_if #(.W(WG)) u_if ();
    std_rr_onehot_arbiter #(.W(WG)) u_dut (
      .i_clk  (clk),
      .i_rst  (rst_n),
      .io_bus (u_if.master)
    );

    initial begin
      logic [WG-1:0] req;
      logic [WG-1:0] exp_g;
      logic [WG-1:0] m_lg;
      logic [WG-1:0] prev_g;
      logic          rdy;
      logic          exp_v;
      bit            m_lk;
      bit            stalled;
      bit            starved;
      int            m_p;
      int            ei;
      int            max_wait;
      int            wait_c [WG];
      string         pfx;

      done = 1'b0;
      pfx = $sformatf("w%0d", WG);
      req = '0;
      rdy = 1'b0;
      m_lg = '0;
      prev_g = '0;
      m_lk = 1'b0;
      stalled = 1'b0;
      starved = 1'b0;
      m_p = 0;
      max_wait = 0;
      foreach (wait_c[k]) wait_c[k] = 0;
      u_if.req = '0;
      u_if.ready = 1'b0;
      wait (rnd_go);
      for (int c = 0; c < 10000; c++) begin
        @(posedge clk);
        #1;
        u_if.req = req;
        u_if.ready = rdy;
        @(negedge clk);
        exp_g = '0;
        ei = 0;
        if (m_lk) begin
          exp_g = m_lg;
        end else begin
          for (int j = 0; j < WG; j++) begin
            if (exp_g == '0 && req[(m_p + j) % WG]) exp_g[(m_p + j) % WG] = 1'b1;
          end
        end
        for (int k = 0; k < WG; k++) if (exp_g[k]) ei = k;
        exp_v = m_lk || (|req);
        chk({pfx, "_valid"}, 64'(u_if.valid), 64'(exp_v));
        chk({pfx, "_grant"}, 64'(u_if.grant), 64'(exp_g));
        chk({pfx, "_index"}, 64'(u_if.index), 64'(ei));
        chk({pfx, "_onehot"}, 64'($onehot(u_if.grant)), 64'(u_if.valid));
        chk({pfx, "_zero"}, 64'(u_if.grant == '0), 64'(!u_if.valid));
        if (stalled) chk({pfx, "_hold"}, 64'(u_if.grant), 64'(prev_g));
        stalled = exp_v && !rdy;
        prev_g = u_if.grant;
        if (exp_v) begin
          if (rdy) begin
            m_p = (ei + 1) % WG;
            m_lk = 1'b0;
            for (int k = 0; k < WG; k++) begin
              if (k == ei) begin
                wait_c[k] = 0;
              end else if (req[k]) begin
                wait_c[k]++;
                if (wait_c[k] > max_wait) max_wait = wait_c[k];
                if (wait_c[k] >= WG) starved = 1'b1;
              end
            end
            req[ei] = 1'b0;
          end else begin
            m_lk = 1'b1;
            m_lg = exp_g;
          end
        end
        req = req | (WG'($urandom()) & WG'($urandom()));
        rdy = ($urandom_range(0, 3) != 0);
      end
      chk({pfx, "_starve"}, 64'(starved), 64'(0));
      chk({pfx, "_maxwait_lt_w"}, 64'(max_wait < WG), 64'(1));
      done = 1'b1;
    end
  end

  initial begin
    logic [3:0] seq_g [5];
    logic [1:0] seq_i [5];
    n_cmp = 0;
    n_err = 0;
    rnd_go = 1'b0;
    rst_n = 1'b0;
    u_if4.req = 4'b0000;
    u_if4.ready = 1'b0;
    seq_g = '{4'b0001, 4'b0010, 4'b0100, 4'b1000, 4'b0001};
    seq_i = '{2'd0, 2'd1, 2'd2, 2'd3, 2'd0};

    #3;
    expect4("reset", 1'b0, 4'b0000, 2'd0);
    repeat (2) @(posedge clk);
    #1;
    rst_n = 1'b1;
    @(negedge clk);
    expect4("post_reset_idle", 1'b0, 4'b0000, 2'd0);

    for (int i = 0; i < 5; i++) begin
      drive(4'b1111, 1'b1);
      expect4($sformatf("rr%0d", i), 1'b1, seq_g[i], seq_i[i]);
    end

    for (int i = 0; i < 3; i++) begin
      drive(4'b1010, 1'b0);
      expect4($sformatf("stall%0d", i), 1'b1, 4'b0010, 2'd1);
    end
    drive(4'b1000, 1'b0);
    expect4("stall_req_change", 1'b1, 4'b0010, 2'd1);
    drive(4'b1000, 1'b1);
    expect4("stall_accept", 1'b1, 4'b0010, 2'd1);
    drive(4'b1000, 1'b1);
    expect4("after_accept", 1'b1, 4'b1000, 2'd3);

    drive(4'b0110, 1'b1);
    expect4("wrap", 1'b1, 4'b0010, 2'd1);

    drive(4'b0100, 1'b0);
    expect4("lock_pre", 1'b1, 4'b0100, 2'd2);
    drive(4'b1001, 1'b0);
    expect4("locked_drop", 1'b1, 4'b0100, 2'd2);
    #2;
    rst_n = 1'b0;
    #1;
    expect4("midlock_reset", 1'b1, 4'b0001, 2'd0);
    #1;
    rst_n = 1'b1;
    drive(4'b1001, 1'b0);
    expect4("after_midlock", 1'b1, 4'b0001, 2'd0);
    drive(4'b0000, 1'b1);

    rnd_go = 1'b1;
    for (int c = 0; c < 12000; c++) begin
      if (g_rnd[0].done && g_rnd[1].done && g_rnd[2].done && g_rnd[3].done) break;
      @(posedge clk);
    end
    chk("rnd_timeout",
        64'(g_rnd[0].done && g_rnd[1].done && g_rnd[2].done && g_rnd[3].done), 64'(1));

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end
endmodule
